// File: rtl/spi_shared_pkg.sv
// Shared types and constants for the SPI slave front end and its shift-register datapath.
// The command word is {opcode[1:0], payload[ADDR_SIZE-1:0]}, shifted MSB first.
package spi_shared_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int WORD_DEF      = ADDR_SIZE_DEF + 2;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    // One spare bit so a full word count never aliases back to zero.
    function automatic int cnt_width(input int word);
        return $clog2(word) + 1;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Serial datapath for the SPI slave: a serial-in word assembler (rx) and a
// parallel-load serial-out byte shifter (tx), each with its own bit counter.
module spi_shift_reg
    import spi_shared_pkg::*;
#(
    parameter  int ADDR_SIZE = ADDR_SIZE_DEF,
    localparam int WORD      = ADDR_SIZE + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    // rx path
    input  logic                 rx_clr,
    input  logic                 rx_start,
    input  logic                 rx_shift,
    input  logic                 serial_in,
    output logic [WORD-1:0]      rx_word,
    output logic                 rx_last,
    output logic                 rx_done,
    // tx path
    input  logic                 tx_clr,
    input  logic                 tx_load,
    input  logic [ADDR_SIZE-1:0] tx_data,
    output logic                 tx_bit_next,
    output logic                 tx_done
);

    localparam int CW = cnt_width(WORD);
    localparam logic [CW-1:0] RX_FULL = CW'(WORD);
    localparam logic [CW-1:0] RX_LAST = CW'(WORD - 1);
    localparam logic [CW-1:0] TX_REM  = CW'(ADDR_SIZE - 1);

    logic [WORD-2:0]      rx_sreg_q, rx_sreg_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [ADDR_SIZE-1:0] tx_sreg_q, tx_sreg_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 rx_shift_ok;

    // Shifting stops once a full word is held, so trailing MOSI bits are dropped.
    assign rx_shift_ok = rx_shift && (rx_cnt_q < RX_FULL);
    assign rx_last     = rx_shift_ok && (rx_cnt_q == RX_LAST);
    assign rx_done     = (rx_cnt_q == RX_FULL);
    assign rx_word     = {rx_sreg_q, serial_in};
    assign tx_done     = tx_busy_q && (tx_cnt_q == '0);

    always_comb begin
        rx_sreg_d = rx_sreg_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_clr) begin
            rx_sreg_d = '0;
            rx_cnt_d  = '0;
        end else if (rx_start) begin
            rx_sreg_d = {{(WORD-2){1'b0}}, serial_in};
            rx_cnt_d  = CW'(1);
        end else if (rx_shift_ok) begin
            rx_sreg_d = {rx_sreg_q[WORD-3:0], serial_in};
            rx_cnt_d  = rx_cnt_q + CW'(1);
        end
    end

    // tx_bit_next is the value MISO takes after this edge; the MSB goes out
    // directly on load so the shift register only holds the remaining bits.
    always_comb begin
        tx_sreg_d   = tx_sreg_q;
        tx_cnt_d    = tx_cnt_q;
        tx_busy_d   = tx_busy_q;
        tx_bit_next = 1'b0;
        if (tx_clr) begin
            tx_sreg_d = '0;
            tx_cnt_d  = '0;
            tx_busy_d = 1'b0;
        end else if (tx_load) begin
            tx_bit_next = tx_data[ADDR_SIZE-1];
            tx_sreg_d   = {tx_data[ADDR_SIZE-2:0], 1'b0};
            tx_cnt_d    = TX_REM;
            tx_busy_d   = 1'b1;
        end else if (tx_busy_q) begin
            if (tx_cnt_q != '0) begin
                tx_bit_next = tx_sreg_q[ADDR_SIZE-1];
                tx_sreg_d   = {tx_sreg_q[ADDR_SIZE-2:0], 1'b0};
                tx_cnt_d    = tx_cnt_q - CW'(1);
            end else begin
                tx_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sreg_q <= '0;
            rx_cnt_q  <= '0;
            tx_sreg_q <= '0;
            tx_cnt_q  <= '0;
            tx_busy_q <= 1'b0;
        end else begin
            rx_sreg_q <= rx_sreg_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_sreg_q <= tx_sreg_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_busy_q <= tx_busy_d;
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: frames MOSI into command words for the RAM stage and
// returns read data on MISO after a read-address / read-data command pair.
module spi_slave_ctrl
    import spi_shared_pkg::*;
#(
    parameter  int ADDR_SIZE = ADDR_SIZE_DEF,
    localparam int WORD      = ADDR_SIZE + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MOSI,
    input  logic                 ss_n,
    output logic [WORD-1:0]      rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 MISO
);

    state_e          state_q, state_d;
    logic [WORD-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            miso_q, miso_d;
    logic            rd_addr_seen_q, rd_addr_seen_d;
    logic            tx_used_q, tx_used_d;

    logic            in_frame, abort;
    logic            rx_clr, rx_start, rx_shift, rx_last, rx_done;
    logic            tx_load, tx_bit_next, tx_done;
    logic [WORD-1:0] rx_word;

    always_comb begin
        in_frame = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
        abort    = (state_q != IDLE) && ss_n;
        rx_clr   = (state_q == IDLE) || abort;
        rx_start = (state_q == CHK_CMD) && !ss_n;
        rx_shift = in_frame && !ss_n;
        // Only one byte is accepted per READ_DATA frame, and only once the command word is in.
        tx_load  = (state_q == READ_DATA) && !ss_n && rx_done && !tx_used_q && tx_valid;
    end

    spi_shift_reg #(
        .ADDR_SIZE(ADDR_SIZE)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .rx_clr     (rx_clr),
        .rx_start   (rx_start),
        .rx_shift   (rx_shift),
        .serial_in  (MOSI),
        .rx_word    (rx_word),
        .rx_last    (rx_last),
        .rx_done    (rx_done),
        .tx_clr     (rx_clr),
        .tx_load    (tx_load),
        .tx_data    (tx_data),
        .tx_bit_next(tx_bit_next),
        .tx_done    (tx_done)
    );

    always_comb begin
        state_d        = state_q;
        rx_valid_d     = rx_last;
        rx_data_d      = rx_last ? rx_word : rx_data_q;
        miso_d         = tx_bit_next;
        rd_addr_seen_d = rd_addr_seen_q;
        tx_used_d      = (state_q == IDLE) ? 1'b0 : (tx_used_q || tx_load);

        if (tx_done) begin
            rd_addr_seen_d = 1'b0;
        end else if (rx_last && (state_q == READ_ADD)) begin
            rd_addr_seen_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!ss_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (ss_n)                state_d = IDLE;
                else if (!MOSI)          state_d = WRITE;
                else if (rd_addr_seen_q) state_d = READ_DATA;
                else                     state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (ss_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_used_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            tx_used_q      <= tx_used_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign MISO     = miso_q;

endmodule
